// File: rtl/code_2421_pkg.sv
// Shared definitions for the 2421 (Aiken) decade counter monitor:
// code constants, FSM encoding, decode result payload and code helpers.
package code_2421_pkg;

    localparam int unsigned CODE_W = 4;
    localparam int unsigned BIN_W  = 4;

    localparam logic [CODE_W-1:0] C0 = 4'b0000;
    localparam logic [CODE_W-1:0] C1 = 4'b0001;
    localparam logic [CODE_W-1:0] C2 = 4'b0010;
    localparam logic [CODE_W-1:0] C3 = 4'b0011;
    localparam logic [CODE_W-1:0] C4 = 4'b0100;
    localparam logic [CODE_W-1:0] C5 = 4'b1011;
    localparam logic [CODE_W-1:0] C6 = 4'b1100;
    localparam logic [CODE_W-1:0] C7 = 4'b1101;
    localparam logic [CODE_W-1:0] C8 = 4'b1110;
    localparam logic [CODE_W-1:0] C9 = 4'b1111;

    // Bit n set means code n is outside the 2421 table (0101..1010).
    localparam logic [15:0] ILLEGAL_MASK = 16'h07E0;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    typedef struct packed {
        logic             legal;
        logic [BIN_W-1:0] bin;
    } dec_t;

    // Next code in counting order; 9 wraps to 0. Illegal codes map to 0.
    function automatic logic [CODE_W-1:0] succ_2421(input logic [CODE_W-1:0] code);
        logic [CODE_W-1:0] nxt;
        case (code)
            C0:      nxt = C1;
            C1:      nxt = C2;
            C2:      nxt = C3;
            C3:      nxt = C4;
            C4:      nxt = C5;
            C5:      nxt = C6;
            C6:      nxt = C7;
            C7:      nxt = C8;
            C8:      nxt = C9;
            default: nxt = C0;
        endcase
        return nxt;
    endfunction

    function automatic dec_t dec_2421(input logic [CODE_W-1:0] code);
        dec_t d;
        d.legal = ~ILLEGAL_MASK[code];
        case (code)
            C1:      d.bin = 4'd1;
            C2:      d.bin = 4'd2;
            C3:      d.bin = 4'd3;
            C4:      d.bin = 4'd4;
            C5:      d.bin = 4'd5;
            C6:      d.bin = 4'd6;
            C7:      d.bin = 4'd7;
            C8:      d.bin = 4'd8;
            C9:      d.bin = 4'd9;
            default: d.bin = 4'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/code_2421_seq_checker_decode.sv
// Combinational 2421 code to binary decoder with legality flag.
module code_2421_seq_checker_decode
    import code_2421_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output dec_t              dec_c
);

    assign dec_c = dec_2421(code);

endmodule

// File: rtl/code_2421_seq_checker.sv
// Self-checking monitor for a 2421 decade counter: decodes the code stream,
// flags illegal codes, wrong successors and carry errors, counts decades.
module code_2421_seq_checker
    import code_2421_pkg::*;
#(
    parameter int unsigned CNT_W        = 8,
    parameter bit          STRICT_CARRY = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              x,
    input  logic [CODE_W-1:0] code_in,
    input  logic              z,
    input  logic              clr_fault,
    output logic [BIN_W-1:0]  bin_out,
    output logic              bin_valid,
    output logic              illegal,
    output logic              seq_err,
    output logic              carry_err,
    output logic              fault,
    output logic [CNT_W-1:0]  decade_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    state_t            state;
    logic [CODE_W-1:0] prev_code;
    logic              prev_x;
    dec_t              dec_c;

    logic [CODE_W-1:0] expected_c;
    logic              z_exp_c;
    logic              ill_c;
    logic              seq_c;
    logic              carry_c;
    logic              any_err_c;
    logic              wrap_c;

    code_2421_seq_checker_decode u_decode (
        .code  (code_in),
        .dec_c (dec_c)
    );

    // Per-cycle checks; only HUNT and TRACK report, FAULT stays silent.
    always_comb begin
        expected_c = prev_x ? succ_2421(prev_code) : prev_code;
        z_exp_c    = x & (code_in == C9);
        ill_c      = ~dec_c.legal & (state != ST_FAULT);
        seq_c      = dec_c.legal & (state == ST_TRACK) & (code_in != expected_c);
        carry_c    = STRICT_CARRY & dec_c.legal & (state == ST_TRACK) & (z != z_exp_c);
        any_err_c  = ill_c | seq_c | carry_c;
        wrap_c     = (state == ST_TRACK) & prev_x & (prev_code == C9) & (code_in == C0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_HUNT;
            prev_code  <= C0;
            prev_x     <= 1'b0;
            bin_out    <= '0;
            bin_valid  <= 1'b0;
            illegal    <= 1'b0;
            seq_err    <= 1'b0;
            carry_err  <= 1'b0;
            fault      <= 1'b0;
            decade_cnt <= '0;
            err_cnt    <= '0;
        end else begin
            bin_out   <= dec_c.legal ? dec_c.bin : '0;
            bin_valid <= dec_c.legal;
            illegal   <= ill_c;
            seq_err   <= seq_c;
            carry_err <= carry_c;
            // A new error outranks a simultaneous clear.
            fault     <= any_err_c | (fault & ~clr_fault);

            if (dec_c.legal) begin
                prev_code <= code_in;
                prev_x    <= x;
            end

            if (any_err_c && err_cnt != '1) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            if (wrap_c && decade_cnt != '1) begin
                decade_cnt <= decade_cnt + CNT_W'(1);
            end

            case (state)
                ST_HUNT:  if (dec_c.legal) state <= ST_TRACK;
                ST_TRACK: if (any_err_c)   state <= ST_FAULT;
                ST_FAULT: if (clr_fault)   state <= ST_HUNT;
                default:                   state <= ST_HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_code_2421_seq_checker.sv
// Bench for code_2421_seq_checker: directed vector table, hand sequences and
// randomized counter traffic checked against a value-level reference model.
module tb_code_2421_seq_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       x;
    logic [3:0] code_in;
    logic       z;
    logic       clr_fault;

    logic [3:0] bin_s, bin_l;
    logic       valid_s, valid_l, ill_s, ill_l, seq_s, seq_l, car_s, car_l, flt_s, flt_l;
    logic [7:0] dec_s, dec_l, err_s, err_l;

    always #5 clk = ~clk;

    code_2421_seq_checker #(.CNT_W(8), .STRICT_CARRY(1'b1)) dut_s (
        .clk(clk), .reset(reset), .x(x), .code_in(code_in), .z(z), .clr_fault(clr_fault),
        .bin_out(bin_s), .bin_valid(valid_s), .illegal(ill_s), .seq_err(seq_s),
        .carry_err(car_s), .fault(flt_s), .decade_cnt(dec_s), .err_cnt(err_s)
    );

    code_2421_seq_checker #(.CNT_W(8), .STRICT_CARRY(1'b0)) dut_l (
        .clk(clk), .reset(reset), .x(x), .code_in(code_in), .z(z), .clr_fault(clr_fault),
        .bin_out(bin_l), .bin_valid(valid_l), .illegal(ill_l), .seq_err(seq_l),
        .carry_err(car_l), .fault(flt_l), .decade_cnt(dec_l), .err_cnt(err_l)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // 2421 code of each decimal digit.
    logic [3:0] codes [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                               4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

    // Reference model, index 0 = strict carry, 1 = carry ignored.
    int m_mode [2];   // 0 hunting, 1 tracking, 2 faulted
    int m_prev [2];
    bit m_prevx[2];
    int m_bin  [2];
    bit m_valid[2], m_ill[2], m_seq[2], m_car[2], m_flt[2];
    int m_dec  [2], m_err[2];

    function automatic int val_of(input logic [3:0] c);
        for (int i = 0; i < 10; i++) if (codes[i] == c) return i;
        return -1;
    endfunction

    task automatic model_step(input int k, input bit r, xi, input logic [3:0] c, input bit zi, ci);
        int v;
        int e;
        bit any;
        if (r) begin
            m_mode[k] = 0; m_prev[k] = 0; m_prevx[k] = 0; m_bin[k] = 0; m_valid[k] = 0;
            m_ill[k] = 0; m_seq[k] = 0; m_car[k] = 0; m_flt[k] = 0; m_dec[k] = 0; m_err[k] = 0;
            return;
        end
        v = val_of(c);
        m_ill[k] = 0; m_seq[k] = 0; m_car[k] = 0;
        if (m_mode[k] == 0) begin
            if (v < 0) m_ill[k] = 1; else m_mode[k] = 1;
        end else if (m_mode[k] == 1) begin
            if (v < 0) m_ill[k] = 1;
            else begin
                e = m_prevx[k] ? (m_prev[k] + 1) % 10 : m_prev[k];
                if (v != e) m_seq[k] = 1;
                if (k == 0 && zi != (xi && v == 9)) m_car[k] = 1;
                if (m_prevx[k] && m_prev[k] == 9 && v == 0 && m_dec[k] < 255) m_dec[k]++;
            end
            if (m_ill[k] || m_seq[k] || m_car[k]) m_mode[k] = 2;
        end else if (ci) begin
            m_mode[k] = 0;
        end
        any = m_ill[k] | m_seq[k] | m_car[k];
        m_flt[k] = any ? 1'b1 : (ci ? 1'b0 : m_flt[k]);
        if (any && m_err[k] < 255) m_err[k]++;
        m_bin[k]   = (v < 0) ? 0 : v;
        m_valid[k] = (v >= 0);
        if (v >= 0) begin
            m_prev[k]  = v;
            m_prevx[k] = xi;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("s.bin_out",    32'(bin_s),   32'(m_bin[0]));
        chk("s.bin_valid",  32'(valid_s), 32'(m_valid[0]));
        chk("s.illegal",    32'(ill_s),   32'(m_ill[0]));
        chk("s.seq_err",    32'(seq_s),   32'(m_seq[0]));
        chk("s.carry_err",  32'(car_s),   32'(m_car[0]));
        chk("s.fault",      32'(flt_s),   32'(m_flt[0]));
        chk("s.decade_cnt", 32'(dec_s),   32'(m_dec[0]));
        chk("s.err_cnt",    32'(err_s),   32'(m_err[0]));
        chk("l.bin_out",    32'(bin_l),   32'(m_bin[1]));
        chk("l.bin_valid",  32'(valid_l), 32'(m_valid[1]));
        chk("l.illegal",    32'(ill_l),   32'(m_ill[1]));
        chk("l.seq_err",    32'(seq_l),   32'(m_seq[1]));
        chk("l.carry_err",  32'(car_l),   32'(m_car[1]));
        chk("l.fault",      32'(flt_l),   32'(m_flt[1]));
        chk("l.decade_cnt", 32'(dec_l),   32'(m_dec[1]));
        chk("l.err_cnt",    32'(err_l),   32'(m_err[1]));
    endtask

    // Drive one cycle of inputs, let the edge take them, then compare with the model.
    task automatic step(input bit r, xi, input logic [3:0] c, input bit zi, ci);
        reset = r; x = xi; code_in = c; z = zi; clr_fault = ci;
        @(posedge clk);
        #1;
        model_step(0, r, xi, c, zi, ci);
        model_step(1, r, xi, c, zi, ci);
        chk_model();
    endtask

    typedef struct {
        bit rst, xi; logic [3:0] code; bit zi, clr;
        int e_bin; bit e_valid, e_ill, e_seq, e_car, e_flt; int e_err;
    } vec_t;

    function automatic vec_t mk(bit r, bit xi, logic [3:0] c, bit zi, bit cl,
                                int b, bit v, bit il, bit sq, bit cr, bit f, int er);
        vec_t t;
        t.rst = r; t.xi = xi; t.code = c; t.zi = zi; t.clr = cl;
        t.e_bin = b; t.e_valid = v; t.e_ill = il; t.e_seq = sq; t.e_car = cr;
        t.e_flt = f; t.e_err = er;
        return t;
    endfunction

    vec_t tbl[$];

    initial begin
        int cv;
        bit xi, zi, ci, ri;
        logic [3:0] c;

        // Hand-computed expectations for the strict-carry instance.
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0001, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0010, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0011, 0, 0, 3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0011, 0, 0, 3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1011, 0, 0, 5, 1, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 4'b1011, 0, 0, 5, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 4'b0100, 0, 1, 4, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0100, 0, 0, 4, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0110, 0, 0, 0, 0, 1, 0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 4'b0100, 0, 1, 4, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 4'b0100, 0, 0, 4, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 4'b1011, 0, 0, 5, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 4'b1100, 0, 0, 6, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 4'b1101, 0, 0, 7, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 4'b1110, 0, 0, 8, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 4'b1111, 0, 0, 9, 1, 0, 0, 1, 1, 3));
        tbl.push_back(mk(1, 1, 4'b1111, 1, 0, 0, 0, 0, 0, 0, 0, 0));

        // 50 ns of reset with idle inputs.
        for (int i = 0; i < 5; i++) step(1, 0, 4'b0000, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].xi, tbl[i].code, tbl[i].zi, tbl[i].clr);
            chk("tbl.bin_out",   32'(bin_s),   32'(tbl[i].e_bin));
            chk("tbl.bin_valid", 32'(valid_s), 32'(tbl[i].e_valid));
            chk("tbl.illegal",   32'(ill_s),   32'(tbl[i].e_ill));
            chk("tbl.seq_err",   32'(seq_s),   32'(tbl[i].e_seq));
            chk("tbl.carry_err", 32'(car_s),   32'(tbl[i].e_car));
            chk("tbl.fault",     32'(flt_s),   32'(tbl[i].e_flt));
            chk("tbl.err_cnt",   32'(err_s),   32'(tbl[i].e_err));
            chk("tbl.lax_carry", 32'(car_l),   32'd0);
        end

        // Full decade with continuous x and a correct carry at 9.
        step(0, 1, codes[0], 0, 0);
        for (int d = 1; d < 10; d++) step(0, 1, codes[d], d == 9, 0);
        step(0, 1, codes[0], 0, 0);
        chk("decade.cnt",   32'(dec_s), 32'd1);
        chk("decade.fault", 32'(flt_s), 32'd0);

        // Reset mid-count clears everything on the next edge.
        step(0, 1, codes[1], 0, 0);
        step(1, 1, codes[2], 0, 0);
        chk("midreset.decade", 32'(dec_s), 32'd0);
        chk("midreset.valid",  32'(valid_s), 32'd0);

        // x toggling every cycle, counter advancing only after x=1 is seen.
        cv = 0;
        step(0, 0, codes[0], 0, 0);
        for (int i = 0; i < 24; i++) begin
            xi = i[0];
            step(0, xi, codes[cv], xi && cv == 9, 0);
            chk("toggle.bin", 32'(bin_s), 32'(cv));
            if (xi) cv = (cv + 1) % 10;
        end
        chk("toggle.fault", 32'(flt_s), 32'd0);

        // Randomized counter traffic with occasional corruption, clears and resets.
        step(1, 0, codes[0], 0, 0);
        cv = 0;
        for (int i = 0; i < 2000; i++) begin
            xi = 1'($urandom_range(0, 1));
            c  = codes[cv];
            zi = xi && cv == 9;
            if ($urandom_range(0, 15) == 0) c = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) zi = ~zi;
            if ($urandom_range(0, 31) == 0) cv = $urandom_range(0, 9);
            ci = ($urandom_range(0, 7) == 0);
            ri = ($urandom_range(0, 199) == 0);
            step(ri, xi, c, zi, ci);
            if (xi) cv = (cv + 1) % 10;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
